// File: rtl/qunion_pkg.sv
// Shared types and helpers for the queue-stream blocks.
package qunion_pkg;

   localparam int unsigned QMAX_LVL = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } grant_state_t;

   // True when the lowest lvl eot bits are all set; lvl=0 closes on every item.
   function automatic logic qlast(input logic [QMAX_LVL-1:0] eot, input int unsigned lvl);
      logic r;
      r = 1'b1;
      for (int unsigned i = 0; i < QMAX_LVL; i++) begin
         if (i < lvl) r = r & eot[i];
      end
      return r;
   endfunction

endpackage

// File: rtl/qunion_mux_arb.sv
// Transaction-boundary arbiter: FSM, round-robin priority and grant decode.
module qunion_arb
   import qunion_pkg::*;
#(
   parameter int unsigned LVL      = 1,
   parameter int unsigned LOCK_LVL = LVL
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           valid0,
   input  logic           valid1,
   input  logic [LVL-1:0] eot0,
   input  logic [LVL-1:0] eot1,
   input  logic           space,
   output logic           grant,
   output logic           grant_valid
);

   grant_state_t        state;
   grant_state_t        state_next;
   logic                prio;
   logic                prio_next;
   logic                last;
   logic                accept;
   logic [QMAX_LVL-1:0] eot_g;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         prio  <= 1'b0;
      end else begin
         state <= state_next;
         prio  <= prio_next;
      end
   end

   always_comb begin
      grant = 1'b0;
      case (state)
         IDLE: begin
            if (valid0 && valid1) grant = prio;
            else                  grant = valid1;
         end
         LOCK0:   grant = 1'b0;
         LOCK1:   grant = 1'b1;
         default: grant = 1'b0;
      endcase

      grant_valid = grant ? valid1 : valid0;

      eot_g          = '0;
      eot_g[LVL-1:0] = grant ? eot1 : eot0;
      last           = qlast(eot_g, LOCK_LVL);
      accept         = grant_valid && space;

      state_next = state;
      prio_next  = prio;
      // Closing a transaction hands preference to the other input.
      if (accept && last) prio_next = ~grant;

      case (state)
         IDLE: begin
            if (accept && !last) state_next = grant ? LOCK1 : LOCK0;
         end
         LOCK0, LOCK1: begin
            if (accept && last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: rtl/qunion_mux.sv
// Merges two queue streams into one tagged stream {eot, ctrl, data} behind a single output register.
module qunion_mux
   import qunion_pkg::*;
#(
   parameter int unsigned W_DIN0   = 16,
   parameter int unsigned W_DIN1   = 16,
   parameter int unsigned LVL      = 1,
   parameter int unsigned LOCK_LVL = LVL,
   parameter int unsigned W_DOUT   = (W_DIN0 > W_DIN1) ? W_DIN0 : W_DIN1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [LVL+W_DIN0-1:0]   din0,
   input  logic                    din0_valid,
   output logic                    din0_ready,
   input  logic [LVL+W_DIN1-1:0]   din1,
   input  logic                    din1_valid,
   output logic                    din1_ready,
   output logic [LVL+1+W_DOUT-1:0] dout,
   output logic                    dout_valid,
   input  logic                    dout_ready
);

   typedef struct packed {
      logic [LVL-1:0]    eot;
      logic              ctrl;
      logic [W_DOUT-1:0] data;
   } out_t;

   out_t out_q;
   out_t out_d;
   logic valid_q;
   logic space;
   logic grant;
   logic grant_valid;
   logic load;

   // Register can take a new item when empty or draining this cycle; never during reset.
   assign space = !rst && (!valid_q || dout_ready);

   qunion_arb #(
      .LVL      (LVL),
      .LOCK_LVL (LOCK_LVL)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .valid0      (din0_valid),
      .valid1      (din1_valid),
      .eot0        (din0[LVL+W_DIN0-1 -: LVL]),
      .eot1        (din1[LVL+W_DIN1-1 -: LVL]),
      .space       (space),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   assign load       = grant_valid && space;
   assign din0_ready = space && !grant;
   assign din1_ready = space && grant;

   always_comb begin
      out_d = '0;
      if (grant) begin
         out_d.eot              = din1[LVL+W_DIN1-1 -: LVL];
         out_d.ctrl             = 1'b1;
         out_d.data[W_DIN1-1:0] = din1[W_DIN1-1:0];
      end else begin
         out_d.eot              = din0[LVL+W_DIN0-1 -: LVL];
         out_d.ctrl             = 1'b0;
         out_d.data[W_DIN0-1:0] = din0[W_DIN0-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= '0;
         valid_q <= 1'b0;
      end else if (load) begin
         out_q   <= out_d;
         valid_q <= 1'b1;
      end else if (dout_ready) begin
         valid_q <= 1'b0;
      end
   end

   assign dout       = out_q;
   assign dout_valid = valid_q;

endmodule

// File: tb/tb_qunion_mux.sv
// Directed scoreboard bench for qunion_mux across three parameter sets.
module tb_qunion_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [17:0] in0 [3];
   logic [17:0] in1 [3];
   logic [2:0]  v0, v1, ordy;
   wire  [2:0]  rd0, rd1, ov;
   wire  [17:0] out_a;
   wire  [18:0] out_b;
   wire  [17:0] out_c;

   int checks   = 0;
   int failures = 0;
   int cur      = 0;
   int cyc      = 0;
   int n_out, first_out, last_out, t_start;
   bit rd1_while0;

   logic [17:0] src0 [$];
   logic [17:0] src1 [$];
   logic [18:0] exp_q [$];

   always #5 clk = ~clk;

   // A: default widths, LOCK_LVL=1
   qunion_mux #(.W_DIN0(16), .W_DIN1(16), .LVL(1), .LOCK_LVL(1)) dut_a (
      .clk(clk), .rst(rst),
      .din0(in0[0][16:0]), .din0_valid(v0[0]), .din0_ready(rd0[0]),
      .din1(in1[0][16:0]), .din1_valid(v1[0]), .din1_ready(rd1[0]),
      .dout(out_a), .dout_valid(ov[0]), .dout_ready(ordy[0])
   );

   // B: mixed widths, two-level eot
   qunion_mux #(.W_DIN0(8), .W_DIN1(16), .LVL(2), .LOCK_LVL(2)) dut_b (
      .clk(clk), .rst(rst),
      .din0(in0[1][9:0]), .din0_valid(v0[1]), .din0_ready(rd0[1]),
      .din1(in1[1][17:0]), .din1_valid(v1[1]), .din1_ready(rd1[1]),
      .dout(out_b), .dout_valid(ov[1]), .dout_ready(ordy[1])
   );

   // C: per-item arbitration
   qunion_mux #(.W_DIN0(16), .W_DIN1(16), .LVL(1), .LOCK_LVL(0)) dut_c (
      .clk(clk), .rst(rst),
      .din0(in0[2][16:0]), .din0_valid(v0[2]), .din0_ready(rd0[2]),
      .din1(in1[2][16:0]), .din1_valid(v1[2]), .din1_ready(rd1[2]),
      .dout(out_c), .dout_valid(ov[2]), .dout_ready(ordy[2])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [18:0] outs(input int k);
      case (k)
         0:       return {1'b0, out_a};
         1:       return out_b;
         default: return {1'b0, out_c};
      endcase
   endfunction

   // {eot, ctrl, data16} for LVL=1 and LVL=2 outputs
   function automatic logic [18:0] pk1(input logic eot, input logic ctrl, input logic [15:0] d);
      return {2'b00, eot, ctrl, d};
   endfunction
   function automatic logic [18:0] pk2(input logic [1:0] eot, input logic ctrl, input logic [15:0] d);
      return {eot, ctrl, d};
   endfunction

   task automatic drive();
      v0 = '0;
      v1 = '0;
      for (int k = 0; k < 3; k++) begin
         in0[k] = '0;
         in1[k] = '0;
      end
      if (src0.size() != 0) begin
         v0[cur]  = 1'b1;
         in0[cur] = src0[0];
      end
      if (src1.size() != 0) begin
         v1[cur]  = 1'b1;
         in1[cur] = src1[0];
      end
   endtask

   task automatic tick();
      logic        a0, a1;
      logic [18:0] o, e;
      logic [17:0] tmp;
      @(negedge clk);
      cyc++;
      if (!rst && ov[cur] && ordy[cur]) begin
         n_out++;
         if (n_out == 1) first_out = cyc;
         last_out = cyc;
         o = outs(cur);
         check("item_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("dout_item", 32'(o), 32'(e));
         end
      end
      if (src0.size() != 0 && rd1[cur]) rd1_while0 = 1'b1;
      a0 = v0[cur] && rd0[cur];
      a1 = v1[cur] && rd1[cur];
      @(posedge clk);
      #1;
      if (a0) tmp = src0.pop_front();
      if (a1) tmp = src1.pop_front();
      drive();
   endtask

   task automatic run(input string tag, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      rst  = 1'b1;
      ordy = '1;
      cur  = 0;

      // Tie at reset: both inputs hold a 3-item transaction
      src0 = '{{1'b0, 16'h1}, {1'b0, 16'h2}, {1'b1, 16'h3}};
      src1 = '{{1'b0, 16'hA}, {1'b0, 16'hB}, {1'b1, 16'hC}};
      drive();
      @(posedge clk);
      @(negedge clk);
      check("rst_ready0", 32'(rd0[0]), 32'd0);
      check("rst_ready1", 32'(rd1[0]), 32'd0);
      check("rst_valid", 32'(ov), 32'd0);
      check("rst_dout", 32'(out_a), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q = '{pk1(0, 0, 16'h1), pk1(0, 0, 16'h2), pk1(1, 0, 16'h3),
                pk1(0, 1, 16'hA), pk1(0, 1, 16'hB), pk1(1, 1, 16'hC)};
      n_out = 0; t_start = cyc;
      run("tie", 30);
      check("tie_latency", 32'(first_out - t_start), 32'd2);
      check("tie_no_gap", 32'(last_out - first_out), 32'd5);

      // Lock holds while din1 arrives mid-transaction
      src0 = '{{1'b0, 16'h21}, {1'b0, 16'h22}, {1'b1, 16'h23}};
      drive();
      rd1_while0 = 1'b0;
      n_out = 0;
      exp_q = '{pk1(0, 0, 16'h21), pk1(0, 0, 16'h22), pk1(1, 0, 16'h23),
                pk1(0, 1, 16'h31), pk1(1, 1, 16'h32)};
      tick();
      src1 = '{{1'b0, 16'h31}, {1'b1, 16'h32}};
      drive();
      run("lock", 30);
      check("lock_din1_blocked", 32'(rd1_while0), 32'd0);
      check("lock_no_gap", 32'(last_out - first_out), 32'd4);

      // Backpressure for 4 cycles with an item buffered
      src0 = '{{1'b0, 16'h41}, {1'b0, 16'h42}, {1'b1, 16'h43}};
      src1 = '{{1'b1, 16'h51}};
      drive();
      n_out = 0;
      exp_q = '{pk1(0, 0, 16'h41), pk1(0, 0, 16'h42), pk1(1, 0, 16'h43), pk1(1, 1, 16'h51)};
      tick();
      ordy[0] = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("bp_valid", 32'(ov[0]), 32'd1);
         check("bp_dout", 32'(out_a), 32'(pk1(0, 0, 16'h41)));
         check("bp_ready0", 32'(rd0[0]), 32'd0);
         check("bp_ready1", 32'(rd1[0]), 32'd0);
      end
      ordy[0] = 1'b1;
      run("bp", 30);
      check("bp_src0_consumed", 32'(src0.size()), 32'd0);

      // Per-item arbitration alternates strictly
      cur = 2;
      src0 = '{{1'b0, 16'h61}, {1'b0, 16'h62}, {1'b0, 16'h63}, {1'b0, 16'h64}};
      src1 = '{{1'b0, 16'h71}, {1'b0, 16'h72}, {1'b0, 16'h73}, {1'b0, 16'h74}};
      drive();
      n_out = 0;
      exp_q = '{pk1(0, 0, 16'h61), pk1(0, 1, 16'h71), pk1(0, 0, 16'h62), pk1(0, 1, 16'h72),
                pk1(0, 0, 16'h63), pk1(0, 1, 16'h73), pk1(0, 0, 16'h64), pk1(0, 1, 16'h74)};
      run("alt", 40);
      check("alt_no_gap", 32'(last_out - first_out), 32'd7);

      // Mixed widths, partial eot must not close a level-2 lock
      cur = 1;
      src0 = '{{8'h00, 2'b01, 8'hFF}, {8'h00, 2'b11, 8'h12}};
      src1 = '{{2'b11, 16'hBEEF}};
      drive();
      exp_q = '{pk2(2'b01, 0, 16'h00FF), pk2(2'b11, 0, 16'h0012), pk2(2'b11, 1, 16'hBEEF)};
      run("width", 30);

      // Reset during LOCK1 discards the buffered item and restores priority
      cur = 0;
      src1 = '{{1'b0, 16'h55}, {1'b0, 16'h56}};
      drive();
      tick();
      rst = 1'b1;
      src0.delete();
      src1.delete();
      drive();
      #1;
      check("rst_mid_ready0", 32'(rd0[0]), 32'd0);
      check("rst_mid_ready1", 32'(rd1[0]), 32'd0);
      tick();
      rst = 1'b0;
      check("post_rst_valid", 32'(ov[0]), 32'd0);
      check("post_rst_dout", 32'(out_a), 32'd0);
      src0 = '{{1'b1, 16'h07}};
      src1 = '{{1'b1, 16'h08}};
      drive();
      exp_q = '{pk1(1, 0, 16'h07), pk1(1, 1, 16'h08)};
      run("post_rst_tie", 20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
